// File: rtl/rec_pkg.sv
// Shared types for the 11-byte record stream {int a; byte b; shortint c; int d}.
// Bytes travel big-endian: byte 0 is a[31:24], byte 10 is d[7:0].
package rec_pkg;

    localparam int REC_BYTES = 11;
    localparam int IDX_W     = $clog2(REC_BYTES);

    typedef struct packed {
        logic [31:0] a;
        logic [7:0]  b;
        logic [15:0] c;
        logic [31:0] d;
    } rec_s;

    typedef enum logic {
        SYNC,
        COLLECT
    } state_e;

endpackage

// File: rtl/sat_counter.sv
// Counter that saturates at all-ones instead of wrapping; async active-low reset.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_l,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    logic [W-1:0] r_cnt;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            r_cnt <= '0;
        end else if (inc && (r_cnt != '1)) begin
            r_cnt <= r_cnt + W'(1);
        end
    end

    assign cnt = r_cnt;

endmodule

// File: rtl/rec_stream_unpacker.sv
// Reassembles 11 big-endian bytes (byte 0 flagged by in_sop) into one rec_s and
// hands it out on a valid/ready port, counting delivered records and framing errors.
module rec_stream_unpacker
    import rec_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_l,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_data,
    input  logic             in_sop,
    output logic             out_valid,
    input  logic             out_ready,
    output rec_s             out_rec,
    output logic [CNT_W-1:0] rec_cnt,
    output logic [CNT_W-1:0] err_cnt
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(REC_BYTES - 1);

    state_e           r_state;
    state_e           w_state_nxt;
    logic [IDX_W-1:0] r_byte_idx;
    logic [IDX_W-1:0] w_idx_nxt;
    logic [7:0]       r_bytes [REC_BYTES-1];
    logic             r_out_valid;
    rec_s             r_out_rec;

    logic             w_accept;
    logic             w_deliver;
    logic             w_store;
    logic [IDX_W-1:0] w_store_idx;
    logic             w_load;
    logic             w_err;
    rec_s             w_rec_asm;

    // Only a completed record that cannot be handed over may stall the byte link.
    assign in_ready  = !((r_byte_idx == LAST_IDX) && r_out_valid && !out_ready);
    assign w_accept  = in_valid && in_ready;
    assign w_deliver = r_out_valid && out_ready;

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_byte_idx;
        w_store     = 1'b0;
        w_store_idx = r_byte_idx;
        w_load      = 1'b0;
        w_err       = 1'b0;
        case (r_state)
            SYNC: begin
                if (w_accept) begin
                    if (in_sop) begin
                        w_store     = 1'b1;
                        w_store_idx = '0;
                        w_idx_nxt   = IDX_W'(1);
                        w_state_nxt = COLLECT;
                    end else begin
                        w_err = 1'b1;
                    end
                end
            end
            COLLECT: begin
                if (w_accept) begin
                    if (in_sop) begin
                        w_err       = 1'b1;
                        w_store     = 1'b1;
                        w_store_idx = '0;
                        w_idx_nxt   = IDX_W'(1);
                    end else if (r_byte_idx == LAST_IDX) begin
                        w_load      = 1'b1;
                        w_idx_nxt   = '0;
                        w_state_nxt = SYNC;
                    end else begin
                        w_store   = 1'b1;
                        w_idx_nxt = r_byte_idx + IDX_W'(1);
                    end
                end
            end
            default: begin
                w_state_nxt = SYNC;
                w_idx_nxt   = '0;
            end
        endcase
    end

    // Byte 10 is taken straight from the link so the record loads on its handshake.
    assign w_rec_asm = {r_bytes[0], r_bytes[1], r_bytes[2], r_bytes[3], r_bytes[4],
                        r_bytes[5], r_bytes[6], r_bytes[7], r_bytes[8], r_bytes[9],
                        in_data};

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            r_state     <= SYNC;
            r_byte_idx  <= '0;
            r_out_valid <= 1'b0;
            r_out_rec   <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_byte_idx <= w_idx_nxt;
            if (w_load) begin
                r_out_valid <= 1'b1;
                r_out_rec   <= w_rec_asm;
            end else if (w_deliver) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    // NOTE: the byte store has no reset; each slot is rewritten before the record that reads it loads.
    always_ff @(posedge clk) begin
        if (w_store) begin
            r_bytes[w_store_idx] <= in_data;
        end
    end

    assign out_valid = r_out_valid;
    assign out_rec   = r_out_rec;

    sat_counter #(.W(CNT_W)) u_rec_cnt (
        .clk   (clk),
        .rst_l (rst_l),
        .inc   (w_deliver),
        .cnt   (rec_cnt)
    );

    sat_counter #(.W(CNT_W)) u_err_cnt (
        .clk   (clk),
        .rst_l (rst_l),
        .inc   (w_err),
        .cnt   (err_cnt)
    );

endmodule

// File: tb/tb_rec_stream_unpacker.sv
// Bench for rec_stream_unpacker: table-driven records with a scoreboard queue, plus
// backpressure, framing, reset and saturation sequences (a CNT_W=2 twin shares the inputs).
module tb_rec_stream_unpacker;
    import rec_pkg::*;

    typedef struct {
        logic [0:10][7:0] bytes;
        rec_s             exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_l = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_sop = 1'b0;
    logic        out_ready = 1'b1;
    logic        in_ready, out_valid;
    rec_s        out_rec;
    logic [15:0] rec_cnt, err_cnt;
    logic        s_in_ready, s_out_valid;
    rec_s        s_out_rec;
    logic [1:0]  s_rec_cnt, s_err_cnt;

    int   n_checks = 0;
    int   n_errs = 0;
    int   cyc = 0;
    int   stall_cnt = 0;
    int   bp_n;
    rec_s sb_q[$];
    int   deliv_cyc[$];
    logic hold_prev = 1'b0;
    rec_s hold_rec;
    vec_t vecs[4];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    rec_stream_unpacker #(.CNT_W(16)) u_dut (
        .clk(clk), .rst_l(rst_l), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_sop(in_sop), .out_valid(out_valid), .out_ready(out_ready),
        .out_rec(out_rec), .rec_cnt(rec_cnt), .err_cnt(err_cnt)
    );

    rec_stream_unpacker #(.CNT_W(2)) u_dut_small (
        .clk(clk), .rst_l(rst_l), .in_valid(in_valid), .in_ready(s_in_ready),
        .in_data(in_data), .in_sop(in_sop), .out_valid(s_out_valid), .out_ready(out_ready),
        .out_rec(s_out_rec), .rec_cnt(s_rec_cnt), .err_cnt(s_err_cnt)
    );

    task automatic check(input string name, input logic [87:0] act, input logic [87:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard / protocol monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (!rst_l) begin
            hold_prev = 1'b0;
        end else begin
            if (hold_prev) begin
                check("hold_valid", out_valid, 1'b1);
                check("hold_rec", out_rec, hold_rec);
            end
            if (!in_ready) stall_cnt++;
            if (out_valid && out_ready) begin
                deliv_cyc.push_back(cyc);
                check("twin_rec", s_out_rec, out_rec);
                check("twin_valid", s_out_valid, out_valid);
                check("sb_nonempty", 88'(sb_q.size() != 0), 88'(1));
                if (sb_q.size() != 0) check("sb_rec", out_rec, sb_q.pop_front());
            end
            hold_prev = out_valid && !out_ready;
            hold_rec  = out_rec;
        end
    end

    task automatic send_byte(input logic [7:0] d, input logic s);
        int n = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_sop   = s;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            n++;
            @(negedge clk);
        end
        if (n >= 100) check("in_ready_timeout", in_ready, 1'b1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_sop   = 1'b0;
    endtask

    task automatic send_rec(input int vi, input bit push);
        for (int k = 0; k < REC_BYTES; k++) begin
            if (k == REC_BYTES - 1 && push) sb_q.push_back(vecs[vi].exp);
            send_byte(vecs[vi].bytes[k], k == 0);
        end
    endtask

    task automatic wait_drain();
        int n = 0;
        while (sb_q.size() != 0 && n < 200) begin
            n++;
            @(negedge clk);
        end
        check("sb_drained", 88'(sb_q.size()), 88'(0));
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 rst_l = 1'b0;
        in_valid = 1'b0;
        #1;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_rec", out_rec, 88'(0));
        check("rst_rec_cnt", rec_cnt, 16'd0);
        check("rst_err_cnt", err_cnt, 16'd0);
        check("rst_in_ready", in_ready, 1'b1);
        sb_q.delete();
        @(negedge clk);
        #1 rst_l = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0].bytes = {8'hAA, 8'hAA, 8'hAA, 8'hAD, 8'hBB, 8'hCC, 8'hCC, 8'hDD, 8'hDD, 8'hDD, 8'hDD};
        vecs[0].exp   = '{a: 32'hAAAAAAAD, b: 8'hBB, c: 16'hCCCC, d: 32'hDDDDDDDD};
        vecs[1].bytes = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09, 8'h0A, 8'h0B};
        vecs[1].exp   = '{a: 32'h01020304, b: 8'h05, c: 16'h0607, d: 32'h08090A0B};
        vecs[2].bytes = {8'h80, 8'h00, 8'h00, 8'h01, 8'hFF, 8'h12, 8'h34, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
        vecs[2].exp   = '{a: 32'h80000001, b: 8'hFF, c: 16'h1234, d: 32'hDEADBEEF};
        vecs[3].bytes = {8'hFE, 8'hDC, 8'hBA, 8'h98, 8'h76, 8'h54, 8'h32, 8'h10, 8'h0F, 8'h1E, 8'h2D};
        vecs[3].exp   = '{a: 32'hFEDCBA98, b: 8'h76, c: 16'h5432, d: 32'h100F1E2D};

        do_reset();

        // Table loop: each record checked for latency, content and count.
        for (int i = 0; i < 4; i++) begin
            for (int k = 0; k < REC_BYTES - 1; k++) send_byte(vecs[i].bytes[k], k == 0);
            check("pre_b10_valid", out_valid, 1'b0);
            sb_q.push_back(vecs[i].exp);
            send_byte(vecs[i].bytes[REC_BYTES-1], 1'b0);
            check("lat_valid", out_valid, 1'b1);
            check("tbl_rec", out_rec, vecs[i].exp);
            wait_drain();
            check("tbl_rec_cnt", rec_cnt, 16'(i + 1));
        end

        // Backpressure: record 2 stalls at byte 10 while record 1 is held.
        out_ready = 1'b0;
        send_rec(1, 1'b1);
        fork
            send_rec(2, 1'b1);
            begin
                bp_n = 0;
                @(negedge clk);
                while (in_ready && bp_n < 200) begin
                    bp_n++;
                    @(negedge clk);
                end
                check("bp_in_ready_low", in_ready, 1'b0);
                check("bp_rec1_held", out_rec, vecs[1].exp);
                repeat (3) @(negedge clk);
                check("bp_still_low", in_ready, 1'b0);
                @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        wait_drain();
        check("bp_rec_cnt", rec_cnt, 16'd6);
        check("bp_err_cnt", err_cnt, 16'd0);

        // Framing: truncated record, then a restart, then stray bytes in SYNC.
        do_reset();
        for (int k = 0; k < 5; k++) send_byte(vecs[0].bytes[k], k == 0);
        send_rec(3, 1'b1);
        wait_drain();
        check("frm_err_cnt", err_cnt, 16'd1);
        check("frm_rec_cnt", rec_cnt, 16'd1);
        for (int k = 0; k < 3; k++) send_byte(8'h11 + 8'(k), 1'b0);
        check("frm_sync_err", err_cnt, 16'd4);
        check("frm_sync_rec", rec_cnt, 16'd1);

        // Reset at byte 6, then reset while a record is held.
        for (int k = 0; k < 6; k++) send_byte(vecs[1].bytes[k], k == 0);
        do_reset();
        send_rec(1, 1'b1);
        wait_drain();
        check("rst1_rec_cnt", rec_cnt, 16'd1);
        out_ready = 1'b0;
        send_rec(2, 1'b0);
        @(negedge clk);
        check("rst2_held", out_valid, 1'b1);
        do_reset();
        out_ready = 1'b1;
        send_rec(0, 1'b1);
        wait_drain();
        check("rst2_rec_cnt", rec_cnt, 16'd1);

        // Saturation: CNT_W=2 twin must stop at 3.
        do_reset();
        for (int r = 0; r < 6; r++) send_rec(r % 4, 1'b1);
        for (int e = 0; e < 5; e++) send_byte(8'(e), 1'b0);
        wait_drain();
        check("sat_rec_big", rec_cnt, 16'd6);
        check("sat_err_big", err_cnt, 16'd5);
        check("sat_rec_small", s_rec_cnt, 2'd3);
        check("sat_err_small", s_err_cnt, 2'd3);

        // Back-to-back throughput.
        do_reset();
        deliv_cyc.delete();
        stall_cnt = 0;
        for (int r = 0; r < 4; r++) send_rec(r, 1'b1);
        wait_drain();
        check("b2b_stalls", 88'(stall_cnt), 88'(0));
        check("b2b_deliveries", 88'(deliv_cyc.size()), 88'(4));
        for (int r = 1; r < deliv_cyc.size(); r++)
            check("b2b_spacing", 88'(deliv_cyc[r] - deliv_cyc[r-1]), 88'(11));
        check("b2b_rec_cnt", rec_cnt, 16'd4);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end

endmodule
